// File: rtl/arb_pkg.sv
// Shared types for the round-robin packet arbiter: FSM encoding, requester count
// and the requester index type.
package arb_pkg;

    typedef enum logic {IDLE, BUSY} arb_state_t;

    localparam int NREQ = 4;

    typedef logic [1:0] req_idx_t;

endpackage

// File: rtl/mux_4_1_varSize.sv
// Plain 4:1 multiplexer of configurable width; the arbiter steers {last, data}
// of the current owner through it.
module mux_4_1_varSize #(
    parameter int WIDTH = 9
) (
    input  logic [1:0]            sel,
    input  logic [3:0][WIDTH-1:0] din,
    output logic [WIDTH-1:0]      dout
);

    assign dout = din[sel];

endmodule

// File: rtl/rr_mux_arbiter.sv
// Four-requester round-robin packet arbiter: grants one producer per packet and
// forwards its beats into a registered valid/ready output stage.
module rr_mux_arbiter
    import arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [3:0]            in_valid,
    input  logic [3:0]            in_last,
    input  logic [3:0][WIDTH-1:0] in_data,
    output logic [3:0]            in_ready,
    output logic [3:0]            grant,
    output logic                  out_valid,
    output logic                  out_last,
    output logic [WIDTH-1:0]      out_data,
    output logic [1:0]            out_src,
    input  logic                  out_ready,
    output logic                  dbg_state
);

    // Handshake: a beat moves on a channel in any cycle where its valid and ready
    // are both high at the rising edge; valid never waits on ready, and once
    // out_valid is raised the output beat holds until out_ready accepts it.

    arb_state_t state, state_nxt;
    req_idx_t   gidx, gidx_nxt;
    req_idx_t   last_gidx, last_nxt;

    logic [3:0][WIDTH:0] mux_in;
    logic [WIDTH:0]      mux_out;
    logic                sel_last;
    logic [WIDTH-1:0]    sel_data;
    logic                busy;
    logic                out_free;
    logic                xfer;

    // First requester strictly after `last`, wrapping; `last` itself is checked last.
    function automatic req_idx_t rr_next(input logic [NREQ-1:0] req, input req_idx_t last);
        req_idx_t idx;
        rr_next = last;
        for (int i = NREQ; i >= 1; i--) begin
            idx = last + req_idx_t'(i);
            if (req[idx]) rr_next = idx;
        end
    endfunction

    always_comb begin
        for (int r = 0; r < NREQ; r++) begin
            mux_in[r] = {in_last[r], in_data[r]};
        end
    end

    mux_4_1_varSize #(.WIDTH(WIDTH + 1)) u_mux (
        .sel  (gidx),
        .din  (mux_in),
        .dout (mux_out)
    );

    assign sel_last = mux_out[WIDTH];
    assign sel_data = mux_out[WIDTH-1:0];

    assign busy      = (state == BUSY);
    assign out_free  = out_ready | ~out_valid;
    assign grant     = busy ? (4'b0001 << gidx) : 4'b0000;
    assign in_ready  = grant & {NREQ{out_free}};
    assign xfer      = busy & in_valid[gidx] & out_free;
    assign dbg_state = state;

    always_comb begin
        state_nxt = state;
        gidx_nxt  = gidx;
        last_nxt  = last_gidx;
        case (state)
            IDLE: begin
                if (|in_valid) begin
                    state_nxt = BUSY;
                    gidx_nxt  = rr_next(in_valid, last_gidx);
                end
            end
            BUSY: begin
                if (xfer && sel_last) begin
                    state_nxt = IDLE;
                    last_nxt  = gidx;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            gidx      <= '0;
            last_gidx <= 2'd3;
        end else begin
            state     <= state_nxt;
            gidx      <= gidx_nxt;
            last_gidx <= last_nxt;
        end
    end

    // A load in the same cycle as a drain keeps out_valid high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_last  <= sel_last;
            out_data  <= sel_data;
            out_src   <= gidx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: per-requester beat stores drive the
// inputs, expected beats and grants are queued and compared as the DUT emits them.
module tb_rr_mux_arbiter;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [3:0]      in_valid;
    logic [3:0]      in_last;
    logic [3:0][7:0] in_data;
    logic [3:0]      in_ready;
    logic [3:0]      grant;
    logic            out_valid;
    logic            out_last;
    logic [7:0]      out_data;
    logic [1:0]      out_src;
    logic            out_ready;
    logic            dbg_state;

    rr_mux_arbiter #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .grant     (grant),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [10:0] exp_q[$];
    logic [3:0]  exp_g[$];

    logic [7:0] data_mem [4][128];
    logic       last_mem [4][128];
    int         gap_mem  [4][128];
    int         rd [4];
    int         wr [4];

    logic        or_force0 = 1'b0;
    logic        rand_bp   = 1'b0;
    logic [7:0]  bp_data   = 8'h00;
    int          bp_cnt    = 0;
    logic        prev_stall = 1'b0;
    logic [11:0] prev_out  = '0;
    logic [3:0]  prev_g    = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic pending();
        pending = 1'b0;
        for (int r = 0; r < 4; r++) if (rd[r] != wr[r]) pending = 1'b1;
    endfunction

    task automatic add_beat(input int r, input logic [7:0] d, input logic l, input int g);
        if (rd[r] == wr[r]) begin
            rd[r] = 0;
            wr[r] = 0;
        end
        data_mem[r][wr[r]] = d;
        last_mem[r][wr[r]] = l;
        gap_mem[r][wr[r]]  = g;
        wr[r]++;
        exp_q.push_back({2'(r), l, d});
    endtask

    // One clock cycle: entered and left at the falling edge.
    task automatic step();
        logic [3:0] acc;
        for (int r = 0; r < 4; r++) begin
            if (rd[r] != wr[r] && gap_mem[r][rd[r]] == 0) begin
                in_valid[r] = 1'b1;
                in_last[r]  = last_mem[r][rd[r]];
                in_data[r]  = data_mem[r][rd[r]];
            end else begin
                in_valid[r] = 1'b0;
                in_last[r]  = 1'b0;
                in_data[r]  = 8'($urandom_range(0, 255));
            end
        end
        if (or_force0) out_ready = 1'b0;
        else if (bp_cnt > 0 && out_valid && out_data == bp_data) begin
            out_ready = 1'b0;
            bp_cnt--;
        end else if (rand_bp) out_ready = 1'($urandom_range(0, 1));
        else out_ready = 1'b1;
        #1;
        if (prev_stall) check("out_stable", {out_valid, out_last, out_src, out_data}, prev_out);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_beat", {out_src, out_last, out_data}, 0);
            else check("out_beat", {out_src, out_last, out_data}, exp_q.pop_front());
        end
        if (out_valid && !out_ready) check("in_ready_blocked", in_ready, 0);
        check("in_ready_owner", in_ready & ~grant, 0);
        if (grant != 4'b0000 && grant != prev_g) begin
            if (exp_g.size() == 0) check("unexpected_grant", grant, 0);
            else check("grant", grant, exp_g.pop_front());
        end
        prev_g     = grant;
        prev_stall = out_valid && !out_ready;
        prev_out   = {out_valid, out_last, out_src, out_data};
        acc        = in_valid & in_ready;
        @(posedge clk);
        #1;
        for (int r = 0; r < 4; r++) begin
            if (rd[r] != wr[r]) begin
                if (gap_mem[r][rd[r]] > 0) gap_mem[r][rd[r]]--;
                else if (acc[r]) rd[r]++;
            end
        end
        @(negedge clk);
    endtask

    task automatic run_drain(input string tag, input int max, output int src_cyc);
        int n = 0;
        src_cyc = -1;
        while (n < max) begin
            if (!pending() && src_cyc < 0) src_cyc = n;
            if (!pending() && exp_q.size() == 0) break;
            step();
            n++;
        end
        check({tag, "_done"}, {31'd0, pending() || exp_q.size() != 0}, 0);
        check({tag, "_grants_left"}, exp_g.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int r;
        int len;
        for (int i = 0; i < 4; i++) begin
            rd[i] = 0;
            wr[i] = 0;
        end
        reset_n   = 1'b0;
        in_valid  = '0;
        in_last   = '0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_grant", grant, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out", {out_valid, out_last, out_src, out_data}, 0);
        check("rst_state", dbg_state, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Fairness: two 2-beat packets per requester, all pending from the start.
        for (int round = 0; round < 2; round++) begin
            for (int q = 0; q < 4; q++) begin
                add_beat(q, 8'($urandom_range(0, 255)), 1'b0, 0);
                add_beat(q, 8'($urandom_range(0, 255)), 1'b1, 0);
                exp_g.push_back(4'b0001 << q);
            end
        end
        run_drain("fair", 200, cyc);
        check("fair_cycles", cyc, 24);

        // Wraparound: last owner 3, requesters 0 and 2 both ask.
        add_beat(0, 8'h11, 1'b0, 0);
        add_beat(0, 8'h12, 1'b1, 0);
        add_beat(2, 8'h21, 1'b0, 0);
        add_beat(2, 8'h22, 1'b1, 0);
        exp_g.push_back(4'b0001);
        exp_g.push_back(4'b0100);
        run_drain("wrap", 100, cyc);

        // Backpressure on the middle beat of a 3-beat packet.
        add_beat(2, 8'hA0, 1'b0, 0);
        add_beat(2, 8'hA1, 1'b0, 0);
        add_beat(2, 8'hA2, 1'b1, 0);
        exp_g.push_back(4'b0100);
        bp_data = 8'hA1;
        bp_cnt  = 3;
        run_drain("bp", 100, cyc);
        check("bp_applied", bp_cnt, 0);

        // Owner stall: requester 1 pauses mid-packet while requester 0 waits.
        add_beat(1, 8'h31, 1'b0, 0);
        add_beat(1, 8'h32, 1'b1, 5);
        add_beat(0, 8'h41, 1'b1, 1);
        exp_g.push_back(4'b0010);
        exp_g.push_back(4'b0001);
        repeat (4) step();
        check("stall_grant", grant, 4'b0010);
        check("stall_in_valid", in_valid, 4'b0001);
        run_drain("stall", 100, cyc);

        // Single-beat packet latency.
        add_beat(3, 8'h5C, 1'b1, 0);
        exp_g.push_back(4'b1000);
        step();
        check("single_grant", grant, 4'b1000);
        check("single_early", out_valid, 0);
        step();
        check("single_out", {out_valid, out_last, out_src, out_data}, {1'b1, 1'b1, 2'd3, 8'h5C});
        run_drain("single", 50, cyc);

        // Random packets one requester at a time with random backpressure and gaps.
        rand_bp = 1'b1;
        for (int k = 0; k < 8; k++) begin
            r   = $urandom_range(0, 3);
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++)
                add_beat(r, 8'($urandom_range(0, 255)), b == len - 1, $urandom_range(0, 2));
            exp_g.push_back(4'b0001 << r);
            run_drain("rand", 200, cyc);
        end
        rand_bp = 1'b0;

        // Reset asserted mid-packet with a beat held in the output stage.
        or_force0 = 1'b1;
        for (int b = 0; b < 4; b++) add_beat(0, 8'h60 + 8'(b), b == 3, 0);
        exp_g.push_back(4'b0001);
        repeat (3) step();
        check("pre_rst_valid", out_valid, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_out", {out_valid, out_last, out_src, out_data}, 0);
        check("mid_rst_grant", {grant, in_ready}, 0);
        for (int i = 0; i < 4; i++) begin
            rd[i] = 0;
            wr[i] = 0;
        end
        exp_q.delete();
        exp_g.delete();
        or_force0  = 1'b0;
        prev_stall = 1'b0;
        prev_g     = '0;
        in_valid   = '0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int q = 0; q < 4; q++) begin
            add_beat(q, 8'h70 + 8'(q), 1'b1, 0);
            exp_g.push_back(4'b0001 << q);
        end
        run_drain("post_rst", 100, cyc);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
